// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared widths and tag type for the Box-Muller log sharing logic
package bm_pkg;

  localparam int U_W         = 48;
  localparam int E_W         = 31;
  localparam int NREQ_DEF    = 4;
  localparam int LOG_LAT_DEF = 2;

  // Tag index is sized for the largest supported channel count so one type serves every build.
  localparam int NREQ_MAX  = 8;
  localparam int TAG_IDX_W = $clog2(NREQ_MAX);

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first eligible channel at or after rr_ptr
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;
  int   slot;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = 0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!found && elig[slot[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[slot[IDX_W-1:0]]   = 1'b1;
        grant_idx                = slot[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/log_share_arbiter.sv
// rtl/log_share_arbiter.sv - shares one fixed-latency log unit between NREQ channels
// Round-robin issue, tag pipeline aligned to the log latency, per-channel result slots held until ack.
module log_share_arbiter #(
  parameter int NREQ    = bm_pkg::NREQ_DEF,
  parameter int LOG_LAT = bm_pkg::LOG_LAT_DEF,
  parameter int U_W     = bm_pkg::U_W,
  parameter int E_W     = bm_pkg::E_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*U_W-1:0] req_u0,
  output logic [NREQ-1:0]     req_ready,
  output logic [U_W-1:0]      log_u0,
  output logic                log_in_valid,
  input  logic [E_W-1:0]      log_e,
  output logic [NREQ-1:0]     res_valid,
  output logic [NREQ*E_W-1:0] res_e,
  input  logic [NREQ-1:0]     res_ack
);

  import bm_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  pending_q, pending_d;
  logic [NREQ-1:0]  res_valid_q, res_valid_d;
  logic [E_W-1:0]   res_e_q [NREQ];
  logic [E_W-1:0]   res_e_d [NREQ];
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [U_W-1:0]   log_u0_q;
  logic             log_in_valid_q;
  tag_t             tag_q [LOG_LAT+1];
  tag_t             tag_in;
  tag_t             tag_out;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [NREQ-1:0]  ack_fire;
  logic [U_W-1:0]   issue_u0;

  // Reset is folded in so no handshake can be reported while the block is held in reset.
  assign elig      = req_valid & ~pending_q & {NREQ{~rst}};
  assign grant_any = |grant;
  assign ack_fire  = res_ack & res_valid_q;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .elig      (elig),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    issue_u0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) issue_u0 = req_u0[i*U_W +: U_W];
    end
  end

  always_comb begin
    tag_in.vld = grant_any;
    tag_in.idx = grant_any ? TAG_IDX_W'(grant_idx) : '0;
    rr_ptr_d   = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign tag_out = tag_q[LOG_LAT];

  // A channel has at most one operation in flight, so an emerging tag never lands on an occupied slot.
  always_comb begin
    pending_d   = (pending_q | grant) & ~ack_fire;
    res_valid_d = res_valid_q & ~ack_fire;
    for (int i = 0; i < NREQ; i++) begin
      res_e_d[i] = res_e_q[i];
      if (tag_out.vld && tag_out.idx == TAG_IDX_W'(i)) begin
        res_valid_d[i] = 1'b1;
        res_e_d[i]     = log_e;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q      <= '0;
      res_valid_q    <= '0;
      rr_ptr_q       <= '0;
      log_u0_q       <= '0;
      log_in_valid_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) res_e_q[i] <= '0;
      for (int k = 0; k <= LOG_LAT; k++) tag_q[k] <= '0;
    end else begin
      pending_q      <= pending_d;
      res_valid_q    <= res_valid_d;
      log_in_valid_q <= grant_any;
      if (grant_any) begin
        rr_ptr_q <= rr_ptr_d;
        log_u0_q <= issue_u0;
      end
      for (int i = 0; i < NREQ; i++) res_e_q[i] <= res_e_d[i];
      tag_q[0] <= tag_in;
      for (int k = 1; k <= LOG_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign log_u0       = log_u0_q;
  assign log_in_valid = log_in_valid_q;
  assign res_valid    = res_valid_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_res_e
    assign res_e[i*E_W +: E_W] = res_e_q[i];
  end

endmodule

// File: tb/tb_log_share_arbiter.sv
// tb/tb_log_share_arbiter.sv - randomized and directed bench with a behavioural channel/result model
module tb_log_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*48-1:0] req_u0;
  logic [NREQ-1:0]   req_ready;
  logic [47:0]       log_u0;
  logic              log_in_valid;
  logic [30:0]       log_e;
  logic [NREQ-1:0]   res_valid;
  logic [NREQ*31-1:0] res_e;
  logic [NREQ-1:0]   res_ack;

  always #5 clk = ~clk;

  log_share_arbiter #(.NREQ(NREQ), .LOG_LAT(LAT), .U_W(48), .E_W(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_u0       (req_u0),
    .req_ready    (req_ready),
    .log_u0       (log_u0),
    .log_in_valid (log_in_valid),
    .log_e        (log_e),
    .res_valid    (res_valid),
    .res_e        (res_e),
    .res_ack      (res_ack)
  );

  // Stub log unit: e = u0[30:0], two cycles after sampling.
  logic [30:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= log_u0[30:0];
    s2 <= s1;
  end
  assign log_e = s2;

  typedef struct {
    int          ch;
    logic [30:0] v;
    int          due;
  } fly_t;

  fly_t        fly[$];
  bit   [3:0]  m_pend, m_rv;
  logic [30:0] m_re [4];
  int          m_ptr;
  logic [47:0] m_lu0;
  bit          m_liv;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  function automatic int m_grant();
    if (rst) return -1;
    for (int k = 0; k < 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (req_valid[i] && !m_pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g = m_grant();
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  function automatic logic [123:0] m_re_flat();
    logic [123:0] f;
    for (int i = 0; i < 4; i++) f[i*31 +: 31] = m_re[i];
    return f;
  endfunction

  task automatic m_clear();
    m_pend = '0;
    m_rv   = '0;
    for (int i = 0; i < 4; i++) m_re[i] = '0;
    m_ptr  = 0;
    m_lu0  = '0;
    m_liv  = 1'b0;
    fly.delete();
  endtask

  // Advances one clock edge and applies the behavioural rules to the model.
  task automatic tick();
    int          g;
    logic [3:0]  ack;
    logic [47:0] u;
    fly_t        nf;
    g   = m_grant();
    ack = res_ack & m_rv;
    if (g >= 0) u = req_u0[g*48 +: 48];
    else        u = '0;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_clear();
    end else begin
      for (int i = 0; i < 4; i++) if (ack[i]) begin m_rv[i] = 1'b0; m_pend[i] = 1'b0; end
      for (int k = fly.size() - 1; k >= 0; k--) begin
        if (fly[k].due == cyc) begin
          m_rv[fly[k].ch] = 1'b1;
          m_re[fly[k].ch] = fly[k].v;
          fly.delete(k);
        end
      end
      if (g >= 0) begin
        m_pend[g] = 1'b1;
        m_ptr     = (g + 1) % 4;
        m_lu0     = u;
        m_liv     = 1'b1;
        nf.ch     = g;
        nf.v      = u[30:0];
        nf.due    = cyc + 1 + LAT;
        fly.push_back(nf);
      end else begin
        m_liv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    res_ack   = '0;
    m_clear();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    req_u0    = {4{48'hABCD_1234_5678}};
    res_ack   = '0;
    m_clear();
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (log_in_valid !== 1'b0) begin bad++; $display("FAIL reset_liv got=%b exp=0", log_in_valid); end
    total++; if (log_u0 !== 48'h0) begin bad++; $display("FAIL reset_log_u0 got=%h exp=0", log_u0); end
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL reset_res_valid got=%b exp=0000", res_valid); end
    total++; if (res_e !== 124'h0) begin bad++; $display("FAIL reset_res_e got=%h exp=0", res_e); end
    tick();
    total++; if (log_in_valid !== 1'b0) begin bad++; $display("FAIL reset_edge_liv got=%b exp=0", log_in_valid); end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_u0           = '0;
    req_u0[48 +: 48] = 48'h0000_1234_5678;
    req_valid        = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    total++; if (log_in_valid !== 1'b1) begin bad++; $display("FAIL single_liv got=%b exp=1", log_in_valid); end
    total++; if (log_u0 !== 48'h0000_1234_5678) begin bad++; $display("FAIL single_log_u0 got=%h exp=000012345678", log_u0); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL single_early_valid edge=%0d got=%b exp=0000", k, res_valid); end
    end
    total++; if (log_in_valid !== 1'b0 || log_u0 !== 48'h0000_1234_5678) begin
      bad++; $display("FAIL single_idle_hold got=%b/%h exp=0/000012345678", log_in_valid, log_u0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (res_valid !== 4'b0010) begin bad++; $display("FAIL single_valid step=%0d got=%b exp=0010", k, res_valid); end
      total++; if (res_e[31 +: 31] !== 31'h1234_5678) begin bad++; $display("FAIL single_res_e step=%0d got=%h exp=12345678", k, res_e[31 +: 31]); end
    end
    res_ack = 4'b0010;
    tick();
    res_ack = '0;
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL single_ack got=%b exp=0000", res_valid); end
  endtask

  task automatic test_round_robin();
    int obs[$];
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 40; c++) begin
      res_ack = m_rv;
      for (int i = 0; i < 4; i++) req_u0[i*48 +: 48] = rnd48();
      #1;
      total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); end
      for (int i = 0; i < 4; i++) if (req_ready[i]) begin obs.push_back(i); break; end
      tick();
      total++; if (res_valid !== m_rv) begin bad++; $display("FAIL rr_res_valid c=%0d got=%b exp=%b", c, res_valid, m_rv); end
      total++; if (res_e !== m_re_flat()) begin bad++; $display("FAIL rr_res_e c=%0d got=%h exp=%h", c, res_e, m_re_flat()); end
    end
    req_valid = '0;
    res_ack   = '0;
    total++; if (obs.size() < 24) begin bad++; $display("FAIL rr_grant_count got=%0d exp>=24", obs.size()); end
    for (int k = 0; k < obs.size(); k++) begin
      total++; if (obs[k] != k % 4) begin bad++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, obs[k], k % 4); end
    end
  endtask

  task automatic test_back_pressure();
    bit seen2   = 1'b0;
    bit regrant = 1'b0;
    int others  = 0;
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c <= 30; c++) begin
      res_ack = (c == 20) ? m_rv : (m_rv & 4'b1011);
      for (int i = 0; i < 4; i++) req_u0[i*48 +: 48] = rnd48();
      #1;
      total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); end
      if (seen2 && c <= 20) begin
        total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL bp_blocked c=%0d got=%b exp=0", c, req_ready[2]); end
        if (req_ready[0] || req_ready[1] || req_ready[3]) others++;
      end
      if (req_ready[2] && c <= 20) seen2 = 1'b1;
      if (req_ready[2] && c >= 21) regrant = 1'b1;
      tick();
      total++; if (res_valid !== m_rv) begin bad++; $display("FAIL bp_res_valid c=%0d got=%b exp=%b", c, res_valid, m_rv); end
    end
    req_valid = '0;
    res_ack   = '0;
    total++; if (others < 10) begin bad++; $display("FAIL bp_others_granted got=%0d exp>=10", others); end
    total++; if (!regrant) begin bad++; $display("FAIL bp_regrant got=0 exp=1"); end
  endtask

  task automatic test_zero();
    do_reset();
    req_u0          = '0;
    req_u0[0 +: 48] = 48'h5555_7777_AAAA;
    req_valid       = 4'b0001;
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    total++; if (res_e[0 +: 31] !== 31'h7777_AAAA) begin bad++; $display("FAIL zero_prior got=%h exp=7777aaaa", res_e[0 +: 31]); end
    res_ack = 4'b0001;
    tick();
    res_ack         = '0;
    req_u0[0 +: 48] = 48'h0;
    req_valid       = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL zero_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (log_in_valid !== 1'b1 || log_u0 !== 48'h0) begin bad++; $display("FAIL zero_issue got=%b/%h exp=1/0", log_in_valid, log_u0); end
    for (int k = 0; k < 3; k++) tick();
    total++; if (res_valid[0] !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=1", res_valid[0]); end
    total++; if (res_e[0 +: 31] !== 31'h0) begin bad++; $display("FAIL zero_res_e got=%h exp=0", res_e[0 +: 31]); end
    res_ack = 4'b0001;
    tick();
    res_ack = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) req_u0[i*48 +: 48] = rnd48();
    req_valid = 4'b1001;
    tick();
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    m_clear();
    #1;
    total++; if (log_in_valid !== 1'b0 || log_u0 !== 48'h0) begin bad++; $display("FAIL rstmid_log got=%b/%h exp=0/0", log_in_valid, log_u0); end
    total++; if (res_valid !== 4'b0000 || res_e !== 124'h0) begin bad++; $display("FAIL rstmid_res got=%b/%h exp=0/0", res_valid, res_e); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL rstmid_ghost c=%0d got=%b exp=0000", c, res_valid); end
    end
  endtask

  task automatic test_ack_and_req();
    do_reset();
    req_u0            = '0;
    req_u0[144 +: 48] = 48'h0000_0BAD_F00D;
    req_valid         = 4'b1000;
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    total++; if (res_valid !== 4'b1000) begin bad++; $display("FAIL ackreq_first got=%b exp=1000", res_valid); end
    req_u0[144 +: 48] = 48'hFFFF_2468_ACE1;
    req_valid         = 4'b1000;
    res_ack           = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ackreq_same_cycle got=%b exp=0000", req_ready); end
    tick();
    res_ack = '0;
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL ackreq_cleared got=%b exp=0000", res_valid); end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL ackreq_next got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL ackreq_early k=%0d got=%b exp=0000", k, res_valid); end
    end
    tick();
    total++; if (res_valid !== 4'b1000) begin bad++; $display("FAIL ackreq_valid got=%b exp=1000", res_valid); end
    total++; if (res_e[93 +: 31] !== 31'h2468_ACE1) begin bad++; $display("FAIL ackreq_res_e got=%h exp=2468ace1", res_e[93 +: 31]); end
    res_ack = 4'b1000;
    tick();
    res_ack = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      res_ack   = 4'($urandom);
      for (int i = 0; i < 4; i++) req_u0[i*48 +: 48] = ($urandom_range(0, 7) == 0) ? 48'h0 : rnd48();
      #1;
      total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); end
      tick();
      total++; if (log_in_valid !== m_liv || log_u0 !== m_lu0) begin
        bad++; $display("FAIL rnd_log c=%0d got=%b/%h exp=%b/%h", c, log_in_valid, log_u0, m_liv, m_lu0);
      end
      total++; if (res_valid !== m_rv) begin bad++; $display("FAIL rnd_res_valid c=%0d got=%b exp=%b", c, res_valid, m_rv); end
      total++; if (res_e !== m_re_flat()) begin bad++; $display("FAIL rnd_res_e c=%0d got=%h exp=%h", c, res_e, m_re_flat()); end
    end
    req_valid = '0;
    res_ack   = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_u0    = '0;
    res_ack   = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_zero();
    test_reset_midflight();
    test_ack_and_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
